// File: rtl/lfsr_pkg.sv
// Shared definitions for the LFSR random source: tap masks, draw FSM states
// and the ceil-log2 helper used to build the rejection mask.
package lfsr_pkg;

    typedef enum logic [1:0] {IDLE, DRAW, RESP} draw_state_e;

    // Bit k-1 set for each polynomial term x^k; every entry is maximal-length.
    function automatic logic [31:0] taps(input int width);
        case (width)
            4:       return 32'h0000_000C;
            5:       return 32'h0000_0014;
            6:       return 32'h0000_0030;
            7:       return 32'h0000_0060;
            8:       return 32'h0000_00B8;
            9:       return 32'h0000_0110;
            10:      return 32'h0000_0240;
            11:      return 32'h0000_0500;
            12:      return 32'h0000_0829;
            13:      return 32'h0000_100D;
            14:      return 32'h0000_2015;
            15:      return 32'h0000_6000;
            16:      return 32'h0000_D008;
            17:      return 32'h0001_2000;
            18:      return 32'h0002_0400;
            19:      return 32'h0004_0023;
            20:      return 32'h0009_0000;
            21:      return 32'h0014_0000;
            22:      return 32'h0030_0000;
            23:      return 32'h0042_0000;
            24:      return 32'h00E1_0000;
            25:      return 32'h0120_0000;
            26:      return 32'h0200_0023;
            27:      return 32'h0400_0013;
            28:      return 32'h0900_0000;
            29:      return 32'h1400_0000;
            30:      return 32'h2000_0029;
            31:      return 32'h4800_0000;
            32:      return 32'h8020_0003;
            default: return 32'h0000_0000;
        endcase
    endfunction

    function automatic int ceil_log2(input logic [31:0] v);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((33'd1 << i) < {1'b0, v}) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/lfsr_core.sv
// Fibonacci shift-left LFSR state register with seed reload and all-zero
// lock-up recovery.
module lfsr_core
    import lfsr_pkg::*;
#(
    parameter int               WIDTH = 16,
    parameter logic [WIDTH-1:0] SEED  = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             RESET_N,
    input  logic             en,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed_in,
    output logic [WIDTH-1:0] state
);

    localparam logic [31:0]      TAP_ALL = taps(WIDTH);
    localparam logic [WIDTH-1:0] TAP     = TAP_ALL[WIDTH-1:0];

    logic [WIDTH-1:0] state_q, state_d;

    always_comb begin
        state_d = state_q;
        if (seed_load)
            state_d = (seed_in == '0) ? SEED : seed_in;
        else if (state_q == '0)
            state_d = SEED;
        else if (en)
            state_d = {state_q[WIDTH-2:0], ^(state_q & TAP)};
    end

    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) state_q <= SEED;
        else          state_q <= state_d;
    end

    assign state = state_q;

endmodule

// File: rtl/lfsr_random_gen.sv
// LFSR random source with a valid/ready draw port returning values in
// [0, limit) by bounded rejection sampling and a fold fallback.
//
// state | meaning
// IDLE  | ready for a request; limit latched on acceptance
// DRAW  | testing one masked candidate per enabled cycle
// RESP  | rsp_data held valid until the consumer takes it
module lfsr_random_gen
    import lfsr_pkg::*;
#(
    parameter int               WIDTH     = 16,
    parameter int               OUT_W     = 5,
    parameter logic [WIDTH-1:0] SEED      = {WIDTH{1'b1}},
    parameter int               MAX_TRIES = 8
) (
    input  logic             clk,
    input  logic             RESET_N,
    input  logic             en,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed_in,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [OUT_W-1:0] limit,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [OUT_W-1:0] rsp_data,
    output logic [WIDTH-1:0] lfsr_state
);

    if (WIDTH < 4 || WIDTH > 32) begin : g_bad_width
        $error("lfsr_random_gen: WIDTH must be within 4..32");
    end
    if (OUT_W < 1 || OUT_W > WIDTH) begin : g_bad_out_w
        $error("lfsr_random_gen: OUT_W must be within 1..WIDTH");
    end
    if (SEED == '0) begin : g_bad_seed
        $error("lfsr_random_gen: SEED must be nonzero");
    end
    if (MAX_TRIES < 1 || MAX_TRIES > 255) begin : g_bad_tries
        $error("lfsr_random_gen: MAX_TRIES must be within 1..255");
    end

    localparam logic [7:0] LAST_TRY = 8'(MAX_TRIES - 1);

    logic [WIDTH-1:0] state;

    lfsr_core #(
        .WIDTH (WIDTH),
        .SEED  (SEED)
    ) u_core (
        .clk       (clk),
        .RESET_N   (RESET_N),
        .en        (en),
        .seed_load (seed_load),
        .seed_in   (seed_in),
        .state     (state)
    );

    draw_state_e      st_q;
    logic [OUT_W-1:0] limit_q;
    logic [OUT_W-1:0] rsp_data_q;
    logic [7:0]       tries_q;
    logic             req_ready_q;
    logic             rsp_valid_q;

    logic [OUT_W-1:0] cand, mask, m;
    logic             accept;
    int               limit_log2;

    assign cand       = state[OUT_W-1:0];
    assign limit_log2 = ceil_log2(32'(limit_q));

    always_comb begin
        mask = '0;
        for (int i = 0; i < OUT_W; i++)
            mask[i] = (limit_q == '0) || (i < limit_log2);
    end

    assign m      = cand & mask;
    assign accept = (limit_q == '0) || (m < limit_q);

    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            st_q        <= IDLE;
            limit_q     <= '0;
            rsp_data_q  <= '0;
            tries_q     <= '0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
        end else begin
            case (st_q)
                IDLE: begin
                    if (req_valid) begin
                        limit_q     <= limit;
                        tries_q     <= '0;
                        req_ready_q <= 1'b0;
                        st_q        <= DRAW;
                    end
                end
                DRAW: begin
                    if (en) begin
                        if (accept) begin
                            rsp_data_q  <= m;
                            rsp_valid_q <= 1'b1;
                            st_q        <= RESP;
                        end else if (tries_q == LAST_TRY) begin
                            // m is below 2*limit here, so the fold lands in range
                            rsp_data_q  <= m - limit_q;
                            rsp_valid_q <= 1'b1;
                            st_q        <= RESP;
                        end else begin
                            tries_q <= tries_q + 8'd1;
                        end
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                        st_q        <= IDLE;
                    end
                end
                default: begin
                    st_q        <= IDLE;
                    req_ready_q <= 1'b1;
                    rsp_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready  = req_ready_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_data   = rsp_data_q;
    assign lfsr_state = state;

endmodule

// File: tb/tb_lfsr_random_gen.sv
// Scoreboard bench for lfsr_random_gen: a polynomial-level model predicts each
// draw at acceptance; a negedge monitor checks responses and the LFSR state.
module tb_lfsr_random_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        RESET_N;
    logic        en, seed_load, req_valid, rsp_ready;
    logic [15:0] seed_in;
    logic [4:0]  limit;
    logic        req_ready, rsp_valid;
    logic [4:0]  rsp_data;
    logic [15:0] lfsr_state;

    logic       en4, sl4, rv4, rr4;
    logic [3:0] si4, st4;
    logic [2:0] lim4, rd4;
    logic       rq4, vv4;

    logic       en5, sl5, rv5, rr5;
    logic [4:0] si5, st5, lim5, rd5;
    logic       rq5, vv5;

    lfsr_random_gen #(.WIDTH(16), .OUT_W(5), .SEED(16'hFFFF), .MAX_TRIES(8)) dut (
        .clk(clk), .RESET_N(RESET_N), .en(en), .seed_load(seed_load), .seed_in(seed_in),
        .req_valid(req_valid), .req_ready(req_ready), .limit(limit),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .lfsr_state(lfsr_state));

    lfsr_random_gen #(.WIDTH(4), .OUT_W(3), .SEED(4'hF), .MAX_TRIES(1)) dut4 (
        .clk(clk), .RESET_N(RESET_N), .en(en4), .seed_load(sl4), .seed_in(si4),
        .req_valid(rv4), .req_ready(rq4), .limit(lim4),
        .rsp_valid(vv4), .rsp_ready(rr4), .rsp_data(rd4), .lfsr_state(st4));

    lfsr_random_gen #(.WIDTH(5), .OUT_W(5), .SEED(5'h1F), .MAX_TRIES(8)) dut5 (
        .clk(clk), .RESET_N(RESET_N), .en(en5), .seed_load(sl5), .seed_in(si5),
        .req_valid(rv5), .req_ready(rq5), .limit(lim5),
        .rsp_valid(vv5), .rsp_ready(rr5), .rsp_data(rd5), .lfsr_state(st5));

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: x^16+x^15+x^13+x^4+1, new bit shifted in at the bottom.
    function automatic int step16(input int s);
        int exps[4] = '{16, 15, 13, 4};
        int fb = 0;
        foreach (exps[k]) fb ^= (s >> (exps[k] - 1)) & 1;
        return ((s << 1) | fb) % 65536;
    endfunction

    // Draw result from the state seen on the first DRAW cycle.
    function automatic int exp_draw(input int s0, input int lim);
        int span = 32;
        int bound, p, m, s;
        s = s0;
        bound = (lim == 0) ? span : lim;
        p = 1;
        while (p < bound) p = p * 2;
        for (int t = 1; t <= 8; t++) begin
            m = (s % span) % p;
            if (lim == 0 || m < lim) return m;
            if (t == 8) return m - lim;
            s = step16(s);
        end
        return -1;
    endfunction

    int m_s;
    int sb_q[$];

    function automatic int model_next();
        if (seed_load) return (seed_in == 16'd0) ? 65535 : int'(seed_in);
        if (m_s == 0) return 65535;
        if (en) return step16(m_s);
        return m_s;
    endfunction

    always @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) m_s <= 65535;
        else begin
            m_s <= model_next();
            if (req_valid) sb_q.push_back(exp_draw(model_next(), int'(limit)));
        end
    end

    bit         seen[32];
    logic       held;
    logic [4:0] hold_data;

    always @(negedge clk) begin
        if (!RESET_N) held <= 1'b0;
        else begin
            check("lfsr_state", 64'(lfsr_state), 64'(m_s));
            if (rsp_valid) begin
                if (held) check("rsp_stable", 64'(rsp_data), 64'(hold_data));
                held      <= !rsp_ready;
                hold_data <= rsp_data;
                if (rsp_ready) begin
                    if (sb_q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL rsp_unexpected: got %0h, expected no response", rsp_data);
                    end else begin
                        check("rsp_data", 64'(rsp_data), 64'(sb_q.pop_front()));
                        seen[rsp_data] <= 1'b1;
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_req(input int lim);
        check("req_ready_idle", 64'(req_ready), 64'd1);
        seed_load = 1'b0;
        req_valid = 1'b1;
        limit     = 5'(lim);
        en        = ($urandom_range(0, 3) != 0);
        tick();
        req_valid = 1'b0;
        for (int w = 0; w < 200 && sb_q.size() != 0; w++) begin
            en        = ($urandom_range(0, 3) != 0);
            rsp_ready = ($urandom_range(0, 1) != 0);
            tick();
        end
        rsp_ready = 1'b0;
        if (sb_q.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL rsp_timeout: got no response within 200 cycles, expected one (limit=%0d)", lim);
            sb_q.delete();
        end
    endtask

    task automatic idle_gap();
        int g;
        g = $urandom_range(0, 3);
        for (int i = 0; i < g; i++) begin
            en        = ($urandom_range(0, 1) != 0);
            seed_load = ($urandom_range(0, 7) == 0);
            seed_in   = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom);
            tick();
        end
        seed_load = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got no finish, expected one before time limit");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt, p16, p4, p5, zeros, nseen;
        logic [4:0] d0;

        RESET_N = 1'b0;
        en = 0; seed_load = 0; seed_in = '0; req_valid = 0; limit = '0; rsp_ready = 0;
        en4 = 0; sl4 = 0; si4 = '0; rv4 = 0; lim4 = '0; rr4 = 0;
        en5 = 0; sl5 = 0; si5 = '0; rv5 = 0; lim5 = '0; rr5 = 0;
        #12 RESET_N = 1'b1;
        #1;
        check("reset_state", 64'(lfsr_state), 64'hFFFF);
        check("reset_req_ready", 64'(req_ready), 64'd1);
        check("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        check("reset_rsp_data", 64'(rsp_data), 64'd0);
        check("reset_state4", 64'(st4), 64'hF);
        check("reset_state5", 64'(st5), 64'h1F);

        en = 1; en4 = 1; en5 = 1;
        cnt = 0; p16 = 0; p4 = 0; p5 = 0; zeros = 0;
        while (p16 == 0 && cnt < 70000) begin
            @(posedge clk);
            #1;
            cnt++;
            if (cnt == 1) check("step1", 64'(lfsr_state), 64'hFFFE);
            if (cnt == 2) check("step2", 64'(lfsr_state), 64'hFFFC);
            if (lfsr_state == 16'd0 || st4 == 4'd0 || st5 == 5'd0) zeros++;
            if (p4 == 0 && st4 == 4'hF) p4 = cnt;
            if (p5 == 0 && st5 == 5'h1F) p5 = cnt;
            if (lfsr_state == 16'hFFFF) p16 = cnt;
        end
        en = 0; en4 = 0; en5 = 0;
        check("period16", 64'(p16), 64'd65535);
        check("period4", 64'(p4), 64'd15);
        check("period5", 64'(p5), 64'd31);
        check("zero_states", 64'(zeros), 64'd0);

        tick();
        seed_in = 16'h1234; seed_load = 1;
        tick();
        seed_load = 0;
        check("seed_load", 64'(lfsr_state), 64'h1234);
        tick(); tick();
        check("seed_hold", 64'(lfsr_state), 64'h1234);
        seed_in = 16'h0000; seed_load = 1;
        tick();
        seed_load = 0;
        check("seed_zero", 64'(lfsr_state), 64'hFFFF);

        // Fold fallback: one try, candidate 7 against limit 5 folds to 2.
        si4 = 4'h7; sl4 = 1;
        tick();
        sl4 = 0;
        check("fold_seed", 64'(st4), 64'h7);
        check("fold_req_ready", 64'(rq4), 64'd1);
        rv4 = 1; lim4 = 3'd5;
        tick();
        rv4 = 0; en4 = 1;
        check("fold_t1_valid", 64'(vv4), 64'd0);
        tick();
        check("fold_t2_valid", 64'(vv4), 64'd1);
        check("fold_data", 64'(rd4), 64'd2);
        rr4 = 1;
        tick();
        rr4 = 0; en4 = 0;
        check("fold_done_valid", 64'(vv4), 64'd0);
        check("fold_done_ready", 64'(rq4), 64'd1);

        // Stall in DRAW, then backpressure in RESP.
        en = 0; rsp_ready = 0;
        check("stall_req_ready", 64'(req_ready), 64'd1);
        req_valid = 1; limit = 5'd6;
        tick();
        req_valid = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("stall_no_rsp", 64'(rsp_valid), 64'd0);
        end
        en = 1;
        for (int w = 0; w < 20 && !rsp_valid; w++) tick();
        check("stall_rsp_arrives", 64'(rsp_valid), 64'd1);
        d0 = rsp_data;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bp_valid", 64'(rsp_valid), 64'd1);
            check("bp_req_ready", 64'(req_ready), 64'd0);
            check("bp_data", 64'(rsp_data), 64'(d0));
        end
        rsp_ready = 1;
        tick();
        rsp_ready = 0; en = 0;
        check("bp_drained", 64'(sb_q.size()), 64'd0);
        sb_q.delete();

        // Reset while stalled in DRAW aborts the draw.
        req_valid = 1; limit = 5'd3;
        tick();
        req_valid = 0;
        tick();
        #1 RESET_N = 1'b0;
        #1;
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_req_ready", 64'(req_ready), 64'd1);
        check("rst_state", 64'(lfsr_state), 64'hFFFF);
        sb_q.delete();
        tick();
        RESET_N = 1'b1;
        tick();
        check("post_rst_req_ready", 64'(req_ready), 64'd1);
        check("post_rst_rsp_valid", 64'(rsp_valid), 64'd0);

        foreach (seen[v]) seen[v] = 0;
        for (int i = 0; i < 1000; i++) begin
            idle_gap();
            do_req(6);
        end
        for (int v = 0; v < 6; v++) check("limit6_value_seen", 64'(seen[v]), 64'd1);
        nseen = 0;
        for (int v = 6; v < 32; v++) nseen += int'(seen[v]);
        check("limit6_out_of_range", 64'(nseen), 64'd0);

        foreach (seen[v]) seen[v] = 0;
        for (int i = 0; i < 300; i++) begin
            idle_gap();
            do_req(0);
        end
        nseen = 0;
        foreach (seen[v]) nseen += int'(seen[v]);
        check("full_range_values_seen", 64'(nseen), 64'd32);

        for (int i = 0; i < 200; i++) begin
            idle_gap();
            do_req($urandom_range(0, 31));
        end

        tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
